// File: rtl/ddp_tx_segmenter.sv
// Multi-channel DDP transmit segmenter: round-robin grant, segment split,
// header word plus payload words into the GearBox packet FIFO.
module ddp_tx_segmenter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 256,
    parameter int HDR_W = 56,
    parameter int LEN_W = 16,
    parameter int MAX_SEG_BYTES = 1024,
    parameter int INTERLEAVE = 0,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int BYTES = DATA_W / 8,
    localparam int EMP_W = $clog2(BYTES)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       reqValid,
    input  logic [NUM_CH*HDR_W-1:0] reqHeader,
    input  logic [NUM_CH*LEN_W-1:0] reqLen,
    output logic [NUM_CH-1:0]       reqReady,
    output logic [CH_W-1:0]         dataSel,
    input  logic [DATA_W-1:0]       dataIn,
    input  logic                    dataEmpty,
    output logic                    dataPop,
    output logic [DATA_W-1:0]       pktData,
    output logic                    pktSop,
    output logic                    pktEop,
    output logic [EMP_W-1:0]        pktEmpty,
    output logic [CH_W-1:0]         pktCh,
    output logic                    pktPush,
    input  logic                    pktFull
);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } state_t;

    state_t state;
    state_t nextState;

    logic [CH_W-1:0]   ptr;
    logic [31:0]       offsetQ [NUM_CH];
    logic [LEN_W-1:0]  remQ [NUM_CH];
    logic [NUM_CH-1:0] activeQ;
    logic [NUM_CH-1:0] readyQ;
    logic [31:0]       wordCnt;

    logic [NUM_CH-1:0] eligible;
    logic              grantValid;
    logic [CH_W-1:0]   grantCh;
    logic [CH_W-1:0]   cand;
    logic [31:0]       remCur;
    logic [31:0]       segCur;
    logic [31:0]       segWords;
    logic [31:0]       newRem;
    logic              lastSeg;
    logic              finalWord;
    logic [DATA_W-1:0] hdrWord;

    assign reqReady = readyQ;
    assign dataSel = ptr;

    // A channel whose completion pulse is showing must not be re-granted
    assign eligible = reqValid & ~readyQ;

    always_comb begin
        grantValid = 1'b0;
        grantCh = '0;
        cand = '0;
        for (int i = 1; i <= NUM_CH; i++) begin
            cand = CH_W'((32'(ptr) + 32'(i)) % 32'(NUM_CH));
            if (!grantValid && eligible[cand]) begin
                grantValid = 1'b1;
                grantCh = cand;
            end
        end
    end

    always_comb begin
        remCur = 32'(remQ[ptr]);
        segCur = (remCur > 32'(MAX_SEG_BYTES)) ? 32'(MAX_SEG_BYTES) : remCur;
        lastSeg = (remCur == segCur);
        segWords = (segCur + 32'(BYTES - 1)) / 32'(BYTES);
        newRem = remCur - segCur;
    end

    always_comb begin
        hdrWord = '0;
        hdrWord[HDR_W-1:0] = reqHeader[32'(ptr) * HDR_W +: HDR_W];
        hdrWord[HDR_W +: 32] = offsetQ[ptr];
        hdrWord[HDR_W + 32] = lastSeg;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        pktPush = 1'b0;
        dataPop = 1'b0;
        pktData = '0;
        pktSop = 1'b0;
        pktEop = 1'b0;
        pktEmpty = '0;
        pktCh = '0;
        finalWord = 1'b0;
        unique case (state)
            IDLE: begin
                if (grantValid) begin
                    nextState = HDR;
                end
            end
            HDR: begin
                if (!pktFull) begin
                    pktPush = 1'b1;
                    pktData = hdrWord;
                    pktSop = 1'b1;
                    pktCh = ptr;
                    if (segCur == 32'd0) begin
                        pktEop = 1'b1;
                        nextState = IDLE;
                    end else begin
                        nextState = DATA;
                    end
                end
            end
            DATA: begin
                if (!pktFull && !dataEmpty) begin
                    pktPush = 1'b1;
                    dataPop = 1'b1;
                    pktData = dataIn;
                    pktCh = ptr;
                    if (wordCnt == 32'd1) begin
                        finalWord = 1'b1;
                        pktEop = 1'b1;
                        pktEmpty = EMP_W'((32'(BYTES) - (segCur % 32'(BYTES))) % 32'(BYTES));
                        if (newRem == 32'd0 || INTERLEAVE != 0) begin
                            nextState = IDLE;
                        end else begin
                            nextState = HDR;
                        end
                    end
                end
            end
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr <= '0;
            wordCnt <= '0;
            readyQ <= '0;
            activeQ <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                offsetQ[i] <= '0;
                remQ[i] <= '0;
            end
        end else begin
            readyQ <= '0;
            if (state == IDLE && grantValid) begin
                ptr <= grantCh;
                // An interleaved channel keeps its context between grants
                if (!activeQ[grantCh]) begin
                    activeQ[grantCh] <= 1'b1;
                    offsetQ[grantCh] <= '0;
                    remQ[grantCh] <= reqLen[32'(grantCh) * LEN_W +: LEN_W];
                end
            end
            if (state == HDR && pktPush) begin
                if (segCur == 32'd0) begin
                    readyQ[ptr] <= 1'b1;
                    activeQ[ptr] <= 1'b0;
                    offsetQ[ptr] <= '0;
                    remQ[ptr] <= '0;
                end else begin
                    wordCnt <= segWords;
                end
            end
            if (state == DATA && pktPush) begin
                wordCnt <= wordCnt - 32'd1;
                if (finalWord) begin
                    if (newRem == 32'd0) begin
                        readyQ[ptr] <= 1'b1;
                        activeQ[ptr] <= 1'b0;
                        offsetQ[ptr] <= '0;
                        remQ[ptr] <= '0;
                    end else begin
                        offsetQ[ptr] <= offsetQ[ptr] + segCur;
                        remQ[ptr] <= LEN_W'(newRem);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ddp_tx_segmenter.sv
// Directed bench for ddp_tx_segmenter: instance 0 whole-message grants,
// instance 1 per-segment interleave.
module tb_ddp_tx_segmenter;

    typedef struct {
        int ch;
        int len;
        int stall;
        int stallAt;
        int expSegs;
        int expWords;
        int expEmp;
        int expOff;
    } vec_t;

    typedef struct {
        logic [255:0] data;
        logic         sop;
        logic         eop;
        logic [4:0]   emp;
        logic [1:0]   ch;
        int           cyc;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]   reqValid [2];
    logic [223:0] reqHeader [2];
    logic [63:0]  reqLen [2];
    logic [3:0]   reqReady [2];
    logic [1:0]   dataSel [2];
    logic [255:0] dataIn [2];
    logic         dataEmpty [2];
    logic         dataPop [2];
    logic [255:0] pktData [2];
    logic         pktSop [2];
    logic         pktEop [2];
    logic [4:0]   pktEmpty [2];
    logic [1:0]   pktCh [2];
    logic         pktPush [2];
    logic         pktFull [2];

    int popCnt [2][4];
    int readyCnt [2][4];
    int readyCyc [2][4];
    int hdrOrd [2][16];
    int hdrN [2];
    int dataCnt [2];
    int cyc = 0;
    int total = 0;
    int bad = 0;
    word_t cap[$];
    vec_t vecs [9];
    int exp0 [4];
    int exp1 [4];

    function automatic logic [255:0] mkWord(input int k, input int ch, input int n);
        return {{6{32'(n) ^ 32'h5A5A_0000}}, 16'(k), 16'(ch), 32'(n)};
    endfunction

    function automatic logic [55:0] hdrOf(input int ch);
        return 56'h12_3456_789A_BC00 + 56'(ch);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gInst
        assign dataIn[g] = mkWord(g, int'(dataSel[g]), popCnt[g][dataSel[g]]);
        ddp_tx_segmenter #(
            .NUM_CH(4),
            .DATA_W(256),
            .HDR_W(56),
            .LEN_W(16),
            .MAX_SEG_BYTES(1024),
            .INTERLEAVE(g)
        ) dut (
            .clock(clk),
            .reset(rst),
            .reqValid(reqValid[g]),
            .reqHeader(reqHeader[g]),
            .reqLen(reqLen[g]),
            .reqReady(reqReady[g]),
            .dataSel(dataSel[g]),
            .dataIn(dataIn[g]),
            .dataEmpty(dataEmpty[g]),
            .dataPop(dataPop[g]),
            .pktData(pktData[g]),
            .pktSop(pktSop[g]),
            .pktEop(pktEop[g]),
            .pktEmpty(pktEmpty[g]),
            .pktCh(pktCh[g]),
            .pktPush(pktPush[g]),
            .pktFull(pktFull[g])
        );
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k);
        word_t w;
        if (pktFull[k]) chk("fullpush", {pktPush[k], dataPop[k]}, 0);
        if (!pktPush[k]) begin
            chk("idlezero", {pktSop[k], pktEop[k], pktEmpty[k], |pktData[k]}, 0);
        end else begin
            if (pktSop[k]) begin
                chk("hdrpop", dataPop[k], 0);
                if (hdrN[k] < 16) hdrOrd[k][hdrN[k]] = int'(pktCh[k]);
                hdrN[k]++;
            end else begin
                chk("datapop", dataPop[k], 1);
                dataCnt[k]++;
            end
            if (k == 0) begin
                w.data = pktData[0];
                w.sop = pktSop[0];
                w.eop = pktEop[0];
                w.emp = pktEmpty[0];
                w.ch = pktCh[0];
                w.cyc = cyc;
                cap.push_back(w);
            end
        end
        if (dataPop[k]) popCnt[k][dataSel[k]]++;
        for (int c = 0; c < 4; c++) begin
            if (reqReady[k][c]) begin
                readyCnt[k][c]++;
                readyCyc[k][c] = cyc;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        mon(0);
        mon(1);
    endtask

    task automatic clearLog();
        cap.delete();
        for (int k = 0; k < 2; k++) begin
            hdrN[k] = 0;
            dataCnt[k] = 0;
            for (int c = 0; c < 4; c++) begin
                readyCnt[k][c] = 0;
                readyCyc[k][c] = -1;
            end
        end
    endtask

    task automatic runMsgs(input int budget, input int stall, input int stallAt);
        int n = 0;
        bit done = 1'b0;
        while ((reqValid[0] != 0 || reqValid[1] != 0) && n < budget) begin
            tick();
            n++;
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 4; c++)
                    if (reqReady[k][c]) reqValid[k][c] = 1'b0;
            if (stall != 0 && !done && dataCnt[0] == stallAt) begin
                done = 1'b1;
                @(posedge clk);
                #1;
                if (stall == 1) pktFull[0] = 1'b1;
                else dataEmpty[0] = 1'b1;
                repeat (3) begin
                    tick();
                    n++;
                    chk("stallpush", pktPush[0], 0);
                    chk("stallpop", dataPop[0], 0);
                end
                @(posedge clk);
                #1;
                pktFull[0] = 1'b0;
                dataEmpty[0] = 1'b0;
            end
        end
        repeat (3) tick();
        chk("msgdone", {reqValid[1], reqValid[0]}, 0);
        reqValid[0] = '0;
        reqValid[1] = '0;
    endtask

    task automatic checkMsg(input vec_t v, input int base, input int startCyc);
        int p = 0;
        int rem = v.len;
        int off = 0;
        int segs = 0;
        int words = 0;
        int pop = base;
        int lastEmp = 0;
        int lastOff = 0;
        int lastCyc = 0;
        int seg;
        int nw;
        word_t w;
        logic [255:0] ew;
        if (cap.size() > 0) chk("hdrlat", cap[0].cyc, startCyc + 2);
        do begin
            if (p >= cap.size()) begin
                chk("trunc", cap.size(), p + 1);
                return;
            end
            w = cap[p];
            p++;
            seg = (rem > 1024) ? 1024 : rem;
            nw = (seg + 31) / 32;
            segs++;
            lastOff = off;
            chk("sop", w.sop, 1);
            chk("hdrch", w.ch, v.ch);
            chk("hdroff", w.data[87:56], off);
            chk("hdrlast", w.data[88], rem == seg);
            chk("hdrfield", w.data[55:0], hdrOf(v.ch));
            chk("hdrpad", |w.data[255:89], 0);
            chk("hdreop", w.eop, nw == 0);
            if (nw == 0) begin
                chk("hdremp", w.emp, 0);
                lastEmp = w.emp;
                lastCyc = w.cyc;
            end
            for (int j = 0; j < nw; j++) begin
                if (p >= cap.size()) begin
                    chk("trunc", cap.size(), p + 1);
                    return;
                end
                w = cap[p];
                p++;
                ew = mkWord(0, v.ch, pop);
                pop++;
                words++;
                chk("dsop", w.sop, 0);
                chk("deop", w.eop, j == nw - 1);
                chk("dch", w.ch, v.ch);
                chk("data", w.data[63:0], ew[63:0]);
                chk("datahi", w.data[255:64] == ew[255:64], 1);
                if (j == nw - 1) begin
                    chk("demp", w.emp, (32 - seg % 32) % 32);
                    lastEmp = w.emp;
                    lastCyc = w.cyc;
                end else begin
                    chk("dempz", w.emp, 0);
                end
            end
            off += seg;
            rem -= seg;
        end while (rem > 0);
        chk("extra", cap.size(), p);
        chk("segs", segs, v.expSegs);
        chk("words", words, v.expWords);
        chk("lastemp", lastEmp, v.expEmp);
        chk("lastoff", lastOff, v.expOff);
        chk("rdycnt", readyCnt[0][v.ch], 1);
        chk("rdylat", readyCyc[0][v.ch], lastCyc + 1);
    endtask

    task automatic doVec(input vec_t v);
        int base;
        int startCyc;
        clearLog();
        base = popCnt[0][v.ch];
        reqLen[0][v.ch * 16 +: 16] = 16'(v.len);
        @(posedge clk);
        #1;
        startCyc = cyc;
        reqValid[0][v.ch] = 1'b1;
        runMsgs(400, v.stall, v.stallAt);
        checkMsg(v, base, startCyc);
    endtask

    initial begin
        vec_t v;
        int n;
        vecs[0] = '{0, 64, 0, 0, 1, 2, 0, 0};
        vecs[1] = '{2, 2500, 0, 0, 3, 79, 28, 2048};
        vecs[2] = '{3, 1024, 1, 5, 1, 32, 0, 0};
        vecs[3] = '{1, 1024, 2, 7, 1, 32, 0, 0};
        vecs[4] = '{0, 0, 0, 0, 1, 0, 0, 0};
        vecs[5] = '{1, 1, 0, 0, 1, 1, 31, 0};
        vecs[6] = '{1, 1025, 0, 0, 2, 33, 31, 1024};
        vecs[7] = '{2, 33, 0, 0, 1, 2, 31, 0};
        vecs[8] = '{3, 2048, 0, 0, 2, 64, 0, 1024};
        exp0 = '{1, 1, 3, 3};
        exp1 = '{1, 3, 1, 3};
        for (int k = 0; k < 2; k++) begin
            reqValid[k] = '0;
            reqLen[k] = '0;
            dataEmpty[k] = 1'b0;
            pktFull[k] = 1'b0;
            for (int c = 0; c < 4; c++) begin
                reqHeader[k][c * 56 +: 56] = hdrOf(c);
                popCnt[k][c] = 0;
            end
        end
        clearLog();
        #1 rst = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 2; k++) begin
            chk("rststate", {pktPush[k], dataPop[k], pktSop[k], pktEop[k], pktEmpty[k],
                             pktCh[k], dataSel[k], reqReady[k], |pktData[k]}, 0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) tick();

        for (int i = 0; i < 9; i++) doVec(vecs[i]);

        // Two channels competing on both instances
        clearLog();
        for (int k = 0; k < 2; k++) begin
            reqLen[k][16 +: 16] = 16'd2048;
            reqLen[k][48 +: 16] = 16'd2048;
        end
        @(posedge clk);
        #1;
        reqValid[0] = 4'b1010;
        reqValid[1] = 4'b1010;
        runMsgs(1000, 0, 0);
        chk("il0_segs", hdrN[0], 4);
        chk("il1_segs", hdrN[1], 4);
        for (int i = 0; i < 4; i++) begin
            chk("il0_order", hdrOrd[0][i], exp0[i]);
            chk("il1_order", hdrOrd[1][i], exp1[i]);
        end
        chk("il0_rdyorder", readyCyc[0][1] < readyCyc[0][3], 1);
        chk("il1_rdyorder", readyCyc[1][1] < readyCyc[1][3], 1);
        chk("il0_words", dataCnt[0], 128);
        chk("il1_words", dataCnt[1], 128);

        // Reset in the middle of the second data word
        clearLog();
        reqLen[0][32 +: 16] = 16'd256;
        @(posedge clk);
        #1 reqValid[0][2] = 1'b1;
        n = 0;
        while (dataCnt[0] < 2 && n < 100) begin
            tick();
            n++;
        end
        chk("rstwait", dataCnt[0], 2);
        rst = 1'b1;
        #1;
        chk("rstmid", {pktPush[0], dataPop[0], pktSop[0], pktEop[0], pktEmpty[0],
                       pktCh[0], dataSel[0], reqReady[0], |pktData[0]}, 0);
        reqValid[0] = '0;
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++)
                popCnt[k][c] = 0;
        repeat (2) tick();
        rst = 1'b0;
        repeat (2) tick();
        v = '{2, 64, 0, 0, 1, 2, 0, 0};
        doVec(v);
        v = '{0, 32, 0, 0, 1, 1, 0, 0};
        doVec(v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ddp_tx_segmenter.md
Name: ddp_tx_segmenter

Overview:
Parametrised multi-channel DDP transmit segmenter. It sits between the RDMAP send side and the GearBox transmit packet FIFO. It arbitrates among NUM_CH queue-pair message requests, splits each message into DDP segments of at most MAX_SEG_BYTES, and emits each segment as one header word followed by payload words popped from the shared data pool. It generalises the existing single-stream DDP transmit path to multiple channels, configurable widths, and optional per-segment interleaving.

Parameters:
NUM_CH, 4, number of request channels (2..16); CH_W = max(1, clog2(NUM_CH)).
DATA_W, 256, payload/packet word width in bits (multiple of 64); BYTES = DATA_W/8.
HDR_W, 56, RDMAP-supplied header width; DATA_W >= HDR_W+33 is required.
LEN_W, 16, message length field width, in bytes.
MAX_SEG_BYTES, 1024, maximum payload bytes per segment (multiple of BYTES).
INTERLEAVE, 0, 0 = whole message per grant; 1 = re-arbitrate after every segment.

Ports:
clock  in  1  block clock
reset  in  1  asynchronous active-high reset
reqValid  in  NUM_CH  per-channel message request; held until reqReady
reqHeader  in  NUM_CH*HDR_W  per-channel header; channel i is at [i*HDR_W +: HDR_W]; stable while reqValid
reqLen  in  NUM_CH*LEN_W  per-channel message length in bytes; stable while reqValid
reqReady  out  NUM_CH  one-cycle completion pulse per channel
dataSel  out  CH_W  channel whose payload is being consumed
dataIn  in  DATA_W  first-word-fall-through payload for dataSel
dataEmpty  in  1  payload FIFO for dataSel is empty
dataPop  out  1  payload pop
pktData  out  DATA_W  packet word
pktSop  out  1  first word of segment
pktEop  out  1  last word of segment
pktEmpty  out  clog2(BYTES)  unused bytes in the eop word
pktCh  out  CH_W  channel of the packet word
pktPush  out  1  write strobe to the GearBox FIFO
pktFull  in  1  GearBox FIFO full

Behaviour:
- Single clock domain: clock. reset is asynchronous and active-high. Reset drives every output to 0, puts the FSM in IDLE, sets the round-robin pointer to ch0, and clears all per-channel contexts (offset = 0, remaining = 0, active = 0).
- Per-channel context: offset[31:0] and remaining[LEN_W-1:0]. It is loaded from reqLen on first grant and cleared when the message completes.
- FSM states: IDLE, HDR, DATA.
- IDLE:
  - Grant the first channel with reqValid=1, searching from ptr+1 round-robin.
  - Set ptr to the granted channel and drive dataSel to it.
  - If no channel is valid, stay in IDLE.
  - Move to HDR on the next cycle, so the grant costs exactly 1 bubble cycle.
- HDR:
  - When pktFull=0, push one word: pktData = {zero pad, last, offset[31:0], header}, with pktSop=1.
  - seg = min(remaining, MAX_SEG_BYTES); last = (remaining == seg).
  - If seg = 0 (zero-length message): also assert pktEop=1 with pktEmpty=0, pulse reqReady, and go to IDLE.
  - Otherwise go to DATA with wordCnt = ceil(seg/BYTES).
  - When pktFull=1, do not push and hold state.
- DATA:
  - Push and pop together, with dataPop = pktPush = !pktFull && !dataEmpty. pktData = dataIn. Decrement wordCnt on each push.
  - On the final word: pktEop=1 and pktEmpty = (BYTES - seg%BYTES) % BYTES.
  - After that word: offset += seg, remaining -= seg.
    - If remaining = 0: pulse reqReady[ch] in the following cycle, clear the context, and go to IDLE.
    - Else if INTERLEAVE=1: go to IDLE; the context is retained and the channel re-competes.
    - Else: go to HDR for the same channel.
- pktSop and pktEop are never both 1 on a data word; both are 1 only on a zero-length header word.
- pktPush is never asserted while pktFull=1. pktData, pktSop, pktEop and pktEmpty are valid only when pktPush=1 and are 0 otherwise.
- offset wraps modulo 2^32 with no error indication.
- reqValid deasserting mid-message is a protocol violation and its behaviour is unspecified. A reset mid-packet truncates the packet; no eop is emitted.

Test Plan:
- NUM_CH=4, DATA_W=256; ch0 with len=64 -> header word (sop=1, offset=0, last=1), then 2 data words with eop on the 2nd and pktEmpty=0; reqReady[0] pulses 1 cycle after the eop push.
- ch2 with len=2500, MAX_SEG_BYTES=1024 -> 3 segments of 1024/1024/452 bytes at offsets 0/1024/2048; last=1 only on the 3rd; the 3rd carries 15 data words and its eop word has pktEmpty=28.
- pktFull held high for 3 cycles mid-DATA -> pktPush=0 and dataPop=0 for those 3 cycles, then the stream resumes with no word lost or duplicated. The same check applies with dataEmpty held high.
- INTERLEAVE=1; ch1 and ch3 both requesting len=2048 -> segment order ch1, ch3, ch1, ch3; reqReady[1] fires before reqReady[3]. With INTERLEAVE=0 the order is ch1, ch1, ch3, ch3.
- ch0 with len=0 -> a single word with sop=eop=1, last=1, pktEmpty=0; reqReady[0] pulses.
- Assert reset during the 2nd data word -> all outputs are 0 immediately; after release, ch0 requesting len=32 restarts at offset 0.
